// File: rtl/filter_display_driver.sv
// rtl/filter_display_driver.sv - live/peak-hold hex display driver for FIR output samples; optional DISPLAY_DP_EN
module filter_display_driver #(
    parameter int DIGIT_CYCLES  = 2_000_000,
    parameter int BLANK_CYCLES  = 500_000,
    parameter int DECAY_SAMPLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       mode_peak,
    output logic [7:0] seg_out,
    output logic       digit_sel,
    output logic [7:0] peak_out
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int DW      = $clog2(DECAY_SAMPLES + 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_SAMPLES - 1);

    typedef enum logic [1:0] {BLANK_A, SHOW_HI, BLANK_B, SHOW_LO} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          phase_done;
    logic [7:0]    live, live_next;
    logic [7:0]    peak, peak_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic [7:0]    snap, snap_next;
    logic [6:0]    seg_r;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
            4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
            4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
            4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
        endcase
    endfunction

    always_comb begin
        live_next = sample_valid ? sample_in : live;
        peak_next = peak;
        dcnt_next = dcnt;
        if (sample_valid) begin
            if (sample_in >= peak) begin
                peak_next = sample_in;
                dcnt_next = '0;
            end else if (dcnt == DECAY_LAST) begin
                peak_next = (peak == 8'd0) ? 8'd0 : peak - 8'd1;
                dcnt_next = '0;
            end else begin
                dcnt_next = dcnt + DW'(1);
            end
        end
    end

    always_comb begin
        phase_done = (state == SHOW_HI || state == SHOW_LO) ? (cnt == DIGIT_LAST) : (cnt == BLANK_LAST);
        state_next = state;
        if (phase_done) begin
            case (state)
                BLANK_A: state_next = SHOW_HI;
                SHOW_HI: state_next = BLANK_B;
                BLANK_B: state_next = SHOW_LO;
                default: state_next = BLANK_A;
            endcase
        end
        // Capture uses the post-edge values so a sample on the entry cycle is shown.
        snap_next = (state == BLANK_A && phase_done) ? (mode_peak ? peak_next : live_next) : snap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK_A;
            cnt       <= '0;
            live      <= 8'd0;
            peak      <= 8'd0;
            dcnt      <= '0;
            snap      <= 8'd0;
            seg_r     <= 7'd0;
            digit_sel <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= phase_done ? '0 : cnt + CW'(1);
            live      <= live_next;
            peak      <= peak_next;
            dcnt      <= dcnt_next;
            snap      <= snap_next;
            digit_sel <= (state_next == BLANK_B) || (state_next == SHOW_LO);
            case (state_next)
                SHOW_HI: seg_r <= font(snap_next[7:4]);
                SHOW_LO: seg_r <= font(snap_next[3:0]);
                default: seg_r <= 7'd0;
            endcase
        end
    end

    assign peak_out = peak;

`ifdef DISPLAY_DP_EN
    logic dp_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_r <= 1'b0;
        else        dp_r <= (state_next == SHOW_LO);
    end

    assign seg_out = {dp_r, seg_r};
`else
    assign seg_out = {1'b0, seg_r};
`endif

endmodule

// File: tb/tb_filter_display_driver.sv
// tb/tb_filter_display_driver.sv - self-checking bench for filter_display_driver
module tb_filter_display_driver;

    localparam int DIG   = 4;
    localparam int BLANK = 2;
    localparam int DECAY = 3;
    localparam int FRAME = 2 * (DIG + BLANK);
`ifdef DISPLAY_DP_EN
    localparam logic [7:0] DP = 8'h80;
`else
    localparam logic [7:0] DP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       sample_valid = 1'b0;
    logic       mode_peak = 1'b0;
    logic [7:0] seg_out;
    logic       digit_sel;
    logic [7:0] peak_out;

    int errors = 0;
    int checks = 0;

    int         m_k;
    int         m_miss;
    logic [7:0] m_live, m_peak, m_snap;
    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    filter_display_driver #(
        .DIGIT_CYCLES(DIG), .BLANK_CYCLES(BLANK), .DECAY_SAMPLES(DECAY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .mode_peak(mode_peak), .seg_out(seg_out), .digit_sel(digit_sel), .peak_out(peak_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg();
        int p = m_k % FRAME;
        if (p >= BLANK && p < BLANK + DIG) return {1'b0, font_tab[m_snap[7:4]]};
        if (p >= 2 * BLANK + DIG)          return DP | {1'b0, font_tab[m_snap[3:0]]};
        return 8'h00;
    endfunction

    function automatic logic exp_sel();
        return (m_k % FRAME) >= (BLANK + DIG);
    endfunction

    task automatic model_reset();
        m_k = 0; m_miss = 0; m_live = 0; m_peak = 0; m_snap = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        sample_valid = v;
        sample_in    = d;
        if (v) begin
            m_live = d;
            if (d >= m_peak) begin
                m_peak = d;
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss == DECAY) begin
                    m_peak = (m_peak == 0) ? 8'd0 : m_peak - 8'd1;
                    m_miss = 0;
                end
            end
        end
        m_k++;
        if (m_k % FRAME == BLANK) m_snap = mode_peak ? m_peak : m_live;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_to(input int k);
        while (m_k < k) step(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        apply_reset();
        mode_peak = 1'b1;
        repeat (5) step(1'b1, 8'hC3);
        rst_n = 1'b0;
        #2;
        checks++;
        if (seg_out !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h expected 00", seg_out); end
        checks++;
        if (digit_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", digit_sel); end
        checks++;
        if (peak_out !== 8'h00) begin errors++; $display("FAIL reset_peak: got %h expected 00", peak_out); end
        mode_peak = 1'b0;
    endtask

    task automatic test_idle_pattern();
        logic [7:0] seg_tab [12];
        logic       sel_tab [12];
        seg_tab = '{8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h00,
                    DP | 8'h3F, DP | 8'h3F, DP | 8'h3F, DP | 8'h3F};
        sel_tab = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (seg_out !== seg_tab[i]) begin errors++; $display("FAIL idle_seg[%0d]: got %h expected %h", i, seg_out, seg_tab[i]); end
            checks++;
            if (digit_sel !== sel_tab[i]) begin errors++; $display("FAIL idle_sel[%0d]: got %b expected %b", i, digit_sel, sel_tab[i]); end
            step(1'b0, 8'h00);
        end
    endtask

    task automatic test_live_sample();
        mode_peak = 1'b0;
        apply_reset();
        step(1'b1, 8'hA7);
        run_to(2);
        checks++;
        if (seg_out !== 8'h77) begin errors++; $display("FAIL live_hi: got %h expected 77", seg_out); end
        run_to(8);
        checks++;
        if (seg_out !== (DP | 8'h07)) begin errors++; $display("FAIL live_lo: got %h expected %h", seg_out, DP | 8'h07); end
    endtask

    task automatic test_snapshot_coherence();
        mode_peak = 1'b0;
        apply_reset();
        step(1'b1, 8'h3C);
        run_to(2);
        checks++;
        if (seg_out !== 8'h4F) begin errors++; $display("FAIL snap_hi: got %h expected 4F", seg_out); end
        run_to(6);
        mode_peak = 1'b1;
        step(1'b1, 8'hFF);
        mode_peak = 1'b0;
        run_to(8);
        checks++;
        if (seg_out !== (DP | 8'h39)) begin errors++; $display("FAIL snap_lo: got %h expected %h", seg_out, DP | 8'h39); end
        run_to(14);
        checks++;
        if (seg_out !== 8'h71) begin errors++; $display("FAIL snap_next_hi: got %h expected 71", seg_out); end
        run_to(20);
        checks++;
        if (seg_out !== (DP | 8'h71)) begin errors++; $display("FAIL snap_next_lo: got %h expected %h", seg_out, DP | 8'h71); end
    endtask

    task automatic test_peak_decay();
        logic [7:0] vals [7];
        logic [7:0] exp  [7];
        vals = '{8'h80, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
        exp  = '{8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7E};
        mode_peak = 1'b1;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vals[i]);
            checks++;
            if (peak_out !== exp[i]) begin errors++; $display("FAIL decay[%0d]: got %h expected %h", i, peak_out, exp[i]); end
        end
    endtask

    task automatic test_peak_zero();
        mode_peak = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h00);
            checks++;
            if (peak_out !== 8'h00) begin errors++; $display("FAIL zero_peak[%0d]: got %h expected 00", i, peak_out); end
        end
    endtask

    task automatic test_reset_mid_digit();
        mode_peak = 1'b1;
        apply_reset();
        step(1'b1, 8'h55);
        run_to(3);
        checks++;
        if (peak_out !== 8'h55 || seg_out !== 8'h6D) begin
            errors++; $display("FAIL mid_pre: got peak %h seg %h expected peak 55 seg 6D", peak_out, seg_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg_out !== 8'h00 || peak_out !== 8'h00 || digit_sel !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got seg %h peak %h sel %b expected 00 00 0", seg_out, peak_out, digit_sel);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seg_out !== exp_seg()) begin errors++; $display("FAIL mid_restart[%0d]: got %h expected %h", i, seg_out, exp_seg()); end
            step(1'b0, 8'h00);
        end
        checks++;
        if (seg_out !== 8'h3F) begin errors++; $display("FAIL mid_restart_hi: got %h expected 3F", seg_out); end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] d;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            mode_peak = 1'($urandom % 2);
            v = ($urandom % 3) != 0;
            d = ($urandom % 5 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 150));
            step(v, d);
            checks++;
            if (seg_out !== exp_seg()) begin errors++; $display("FAIL rand_seg[%0d]: got %h expected %h", i, seg_out, exp_seg()); end
            checks++;
            if (digit_sel !== exp_sel()) begin errors++; $display("FAIL rand_sel[%0d]: got %b expected %b", i, digit_sel, exp_sel()); end
            checks++;
            if (peak_out !== m_peak) begin errors++; $display("FAIL rand_peak[%0d]: got %h expected %h", i, peak_out, m_peak); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_pattern();
        test_live_sample();
        test_snapshot_coherence();
        test_peak_decay();
        test_peak_zero();
        test_reset_mid_digit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
